// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter.
// Two pixel writers share one back-buffer write port with round-robin
// arbitration. A buffer exchange is requested by swap_req and carried out
// at the start of a fresh vertical blank. Writes are blocked while an
// exchange is pending.
module fb_write_arbiter #(
  parameter int COORD_W  = 12,
  parameter int DATA_W   = 12,
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               vblank,
  input  logic               r0_valid,
  input  logic [COORD_W-1:0] r0_x,
  input  logic [COORD_W-1:0] r0_y,
  input  logic [DATA_W-1:0]  r0_data,
  output logic               r0_ready,
  input  logic               r1_valid,
  input  logic [COORD_W-1:0] r1_x,
  input  logic [COORD_W-1:0] r1_y,
  input  logic [DATA_W-1:0]  r1_data,
  output logic               r1_ready,
  input  logic               swap_req,
  output logic               swap_done,
  output logic               select,
  output logic               wen,
  output logic [COORD_W-1:0] wx,
  output logic [COORD_W-1:0] wy,
  output logic [DATA_W-1:0]  wdata,
  output logic [7:0]         swap_count
);

  // Swap sequencer states.
  localparam logic [1:0] RUN   = 2'd0;  // writes allowed
  localparam logic [1:0] PEND  = 2'd1;  // waiting for vblank to be low
  localparam logic [1:0] ARMED = 2'd2;  // waiting for vblank to rise
  localparam logic [1:0] SWAP  = 2'd3;  // exchange happens on exit

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_ACTIVE);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               last_r1;   // 1 when r1 won the most recent transfer
  logic               gnt0;
  logic               gnt1;
  logic               run;
  logic               xfer;
  logic               xfer1;
  logic [COORD_W-1:0] acc_x;
  logic [COORD_W-1:0] acc_y;
  logic [DATA_W-1:0]  acc_data;
  logic               in_range;

  // Round-robin grant: a lone requester wins; on a tie the requester that
  // did not win last time goes first.
  always_comb begin
    gnt1 = r1_valid && (!r0_valid || !last_r1);
    gnt0 = r0_valid && !gnt1;
  end

  assign run      = (state == RUN);
  assign r0_ready = run && gnt0;
  assign r1_ready = run && gnt1;

  assign xfer1 = r1_valid && r1_ready;
  assign xfer  = (r0_valid && r0_ready) || xfer1;

  // Mux the accepted pixel and decide whether it lands inside the frame.
  always_comb begin
    acc_x    = xfer1 ? r1_x    : r0_x;
    acc_y    = xfer1 ? r1_y    : r0_y;
    acc_data = xfer1 ? r1_data : r0_data;
    in_range = (acc_x < X_LIM) && (acc_y < Y_LIM);
  end

  // Next-state logic for the swap sequencer.
  always_comb begin
    // NOTE: assign a default first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      RUN:     if (swap_req) state_nxt = PEND;
      PEND:    if (!vblank)  state_nxt = ARMED;
      ARMED:   if (vblank)   state_nxt = SWAP;
      SWAP:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!aresetn) state <= RUN;
    else          state <= state_nxt;
  end

  // Round-robin pointer moves only when a transfer actually completes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  last_r1 <= 1'b1;  // r0 wins the first tie
    else if (xfer) last_r1 <= xfer1;
  end

  // Registered write port; coordinates and data hold while idle or clipped.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wen   <= 1'b0;
      wx    <= '0;
      wy    <= '0;
      wdata <= '0;
    end else begin
      wen <= xfer && in_range;
      if (xfer && in_range) begin
        wx    <= acc_x;
        wy    <= acc_y;
        wdata <= acc_data;
      end
    end
  end

  // Buffer exchange: toggle select, pulse swap_done and count on SWAP exit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      select     <= 1'b0;
      swap_done  <= 1'b0;
      swap_count <= 8'd0;
    end else begin
      swap_done <= (state == SWAP);
      if (state == SWAP) begin
        select     <= ~select;
        swap_count <= swap_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed testbench for fb_write_arbiter. Inputs change on the falling
// edge; outputs are sampled 1ns after the falling edge.
module tb_fb_write_arbiter;

  localparam int COORD_W = 12;
  localparam int DATA_W  = 12;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic               vblank;
  logic               r0_valid;
  logic [COORD_W-1:0] r0_x, r0_y;
  logic [DATA_W-1:0]  r0_data;
  logic               r0_ready;
  logic               r1_valid;
  logic [COORD_W-1:0] r1_x, r1_y;
  logic [DATA_W-1:0]  r1_data;
  logic               r1_ready;
  logic               swap_req;
  logic               swap_done;
  logic               select;
  logic               wen;
  logic [COORD_W-1:0] wx, wy;
  logic [DATA_W-1:0]  wdata;
  logic [7:0]         swap_count;

  int passed = 0;
  int total  = 0;

  fb_write_arbiter #(
    .COORD_W(COORD_W), .DATA_W(DATA_W), .H_ACTIVE(320), .V_ACTIVE(240)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .vblank(vblank),
    .r0_valid(r0_valid), .r0_x(r0_x), .r0_y(r0_y), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_x(r1_x), .r1_y(r1_y), .r1_data(r1_data), .r1_ready(r1_ready),
    .swap_req(swap_req), .swap_done(swap_done), .select(select),
    .wen(wen), .wx(wx), .wy(wy), .wdata(wdata), .swap_count(swap_count)
  );

  always #5 aclk = ~aclk;

  // Hold reset for two cycles and release it on a falling edge.
  task automatic apply_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #1;
    total++; if (select !== 1'b0) $display("FAIL rst_select got=%0b exp=0", select); else passed++;
    total++; if (wen !== 1'b0) $display("FAIL rst_wen got=%0b exp=0", wen); else passed++;
    total++; if (swap_done !== 1'b0) $display("FAIL rst_swap_done got=%0b exp=0", swap_done); else passed++;
    total++; if (swap_count !== 8'd0) $display("FAIL rst_swap_count got=%0d exp=0", swap_count); else passed++;
    total++; if (wx !== 12'd0) $display("FAIL rst_wx got=%0d exp=0", wx); else passed++;
    total++; if (wy !== 12'd0) $display("FAIL rst_wy got=%0d exp=0", wy); else passed++;
    total++; if (wdata !== 12'h000) $display("FAIL rst_wdata got=%h exp=000", wdata); else passed++;
  endtask

  // Both requesters valid from reset: grants alternate r0,r1,r0,r1.
  task automatic test_tie();
    logic [DATA_W-1:0] exp_d;
    apply_reset();
    r0_valid = 1'b1; r0_x = 12'd10; r0_y = 12'd20; r0_data = 12'h111;
    r1_valid = 1'b1; r1_x = 12'd30; r1_y = 12'd40; r1_data = 12'h222;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (r0_ready !== ((i % 2) == 0)) $display("FAIL tie_r0_ready[%0d] got=%0b exp=%0b", i, r0_ready, (i % 2) == 0); else passed++;
      total++; if (r1_ready !== ((i % 2) == 1)) $display("FAIL tie_r1_ready[%0d] got=%0b exp=%0b", i, r1_ready, (i % 2) == 1); else passed++;
      if (i > 0) begin
        exp_d = (((i - 1) % 2) == 0) ? 12'h111 : 12'h222;
        total++; if (wen !== 1'b1) $display("FAIL tie_wen[%0d] got=%0b exp=1", i, wen); else passed++;
        total++; if (wdata !== exp_d) $display("FAIL tie_wdata[%0d] got=%h exp=%h", i, wdata, exp_d); else passed++;
      end
      @(negedge aclk);
    end
    #1;
    total++; if (wen !== 1'b1) $display("FAIL tie_wen_last got=%0b exp=1", wen); else passed++;
    total++; if (wdata !== 12'h222) $display("FAIL tie_wdata_last got=%h exp=222", wdata); else passed++;
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  // Single r1 write: visible one cycle later, then held with wen low.
  task automatic test_latency();
    @(negedge aclk);
    r1_valid = 1'b1; r1_x = 12'd5; r1_y = 12'd7; r1_data = 12'hABC;
    #1;
    total++; if (r1_ready !== 1'b1) $display("FAIL lat_r1_ready got=%0b exp=1", r1_ready); else passed++;
    @(negedge aclk);
    r1_valid = 1'b0;
    #1;
    total++; if (wen !== 1'b1) $display("FAIL lat_wen got=%0b exp=1", wen); else passed++;
    total++; if (wx !== 12'd5) $display("FAIL lat_wx got=%0d exp=5", wx); else passed++;
    total++; if (wy !== 12'd7) $display("FAIL lat_wy got=%0d exp=7", wy); else passed++;
    total++; if (wdata !== 12'hABC) $display("FAIL lat_wdata got=%h exp=abc", wdata); else passed++;
    @(negedge aclk);
    #1;
    total++; if (wen !== 1'b0) $display("FAIL hold_wen got=%0b exp=0", wen); else passed++;
    total++; if (wx !== 12'd5) $display("FAIL hold_wx got=%0d exp=5", wx); else passed++;
    total++; if (wdata !== 12'hABC) $display("FAIL hold_wdata got=%h exp=abc", wdata); else passed++;
  endtask

  // Out-of-frame writes are accepted but never strobe wen.
  task automatic test_clip();
    @(negedge aclk);
    r0_valid = 1'b1; r0_x = 12'd320; r0_y = 12'd0; r0_data = 12'h777;
    #1;
    total++; if (r0_ready !== 1'b1) $display("FAIL clip_x_ready got=%0b exp=1", r0_ready); else passed++;
    @(negedge aclk);
    r0_x = 12'd0; r0_y = 12'd240; r0_data = 12'h888;
    #1;
    total++; if (r0_ready !== 1'b1) $display("FAIL clip_y_ready got=%0b exp=1", r0_ready); else passed++;
    total++; if (wen !== 1'b0) $display("FAIL clip_x_wen got=%0b exp=0", wen); else passed++;
    total++; if (wx !== 12'd5) $display("FAIL clip_x_wx got=%0d exp=5", wx); else passed++;
    @(negedge aclk);
    r0_valid = 1'b0;
    #1;
    total++; if (wen !== 1'b0) $display("FAIL clip_y_wen got=%0b exp=0", wen); else passed++;
    total++; if (wdata !== 12'hABC) $display("FAIL clip_y_wdata got=%h exp=abc", wdata); else passed++;
  endtask

  // swap_req pulse during vblank: exchange waits for a fresh blank.
  task automatic test_swap();
    @(negedge aclk);
    vblank = 1'b1; swap_req = 1'b1;
    r0_valid = 1'b1; r0_x = 12'd1; r0_y = 12'd1; r0_data = 12'h5A5;
    #1;
    total++; if (r0_ready !== 1'b1) $display("FAIL swp_run_ready got=%0b exp=1", r0_ready); else passed++;
    @(negedge aclk);  // PEND
    swap_req = 1'b0;
    #1;
    total++; if (wen !== 1'b1) $display("FAIL swp_inflight_wen got=%0b exp=1", wen); else passed++;
    total++; if (wdata !== 12'h5A5) $display("FAIL swp_inflight_wdata got=%h exp=5a5", wdata); else passed++;
    total++; if (select !== 1'b0) $display("FAIL swp_inflight_select got=%0b exp=0", select); else passed++;
    total++; if (r0_ready !== 1'b0) $display("FAIL swp_pend_ready got=%0b exp=0", r0_ready); else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);  // still PEND: vblank never fell
      #1;
      total++; if (select !== 1'b0) $display("FAIL swp_pend_select[%0d] got=%0b exp=0", i, select); else passed++;
      total++; if (r0_ready !== 1'b0) $display("FAIL swp_pend_ready[%0d] got=%0b exp=0", i, r0_ready); else passed++;
    end
    vblank = 1'b0;
    @(negedge aclk);  // ARMED
    vblank = 1'b1;
    #1;
    total++; if (select !== 1'b0) $display("FAIL swp_armed_select got=%0b exp=0", select); else passed++;
    total++; if (r0_ready !== 1'b0) $display("FAIL swp_armed_ready got=%0b exp=0", r0_ready); else passed++;
    @(negedge aclk);  // SWAP
    #1;
    total++; if (select !== 1'b0) $display("FAIL swp_swap_select got=%0b exp=0", select); else passed++;
    total++; if (swap_done !== 1'b0) $display("FAIL swp_swap_done got=%0b exp=0", swap_done); else passed++;
    total++; if (r0_ready !== 1'b0) $display("FAIL swp_swap_ready got=%0b exp=0", r0_ready); else passed++;
    @(negedge aclk);  // RUN
    #1;
    total++; if (select !== 1'b1) $display("FAIL swp_select got=%0b exp=1", select); else passed++;
    total++; if (swap_done !== 1'b1) $display("FAIL swp_done got=%0b exp=1", swap_done); else passed++;
    total++; if (swap_count !== 8'd1) $display("FAIL swp_count got=%0d exp=1", swap_count); else passed++;
    total++; if (r0_ready !== 1'b1) $display("FAIL swp_resume_ready got=%0b exp=1", r0_ready); else passed++;
    r0_valid = 1'b0;
    @(negedge aclk);
    #1;
    total++; if (swap_done !== 1'b0) $display("FAIL swp_done_pulse got=%0b exp=0", swap_done); else passed++;
  endtask

  // swap_req held high across three vblank rises gives three exchanges.
  task automatic test_held();
    int pulses;
    pulses = 0;
    swap_req = 1'b0; vblank = 1'b0;
    apply_reset();
    swap_req = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      vblank = ((cyc % 6) >= 3);
      #1;
      if (swap_done === 1'b1) pulses++;
      if (pulses == 3) break;
      @(negedge aclk);
    end
    total++; if (pulses != 3) $display("FAIL held_pulses got=%0d exp=3", pulses); else passed++;
    total++; if (swap_count !== 8'd3) $display("FAIL held_count got=%0d exp=3", swap_count); else passed++;
    total++; if (select !== 1'b1) $display("FAIL held_select got=%0b exp=1", select); else passed++;
    swap_req = 1'b0;
  endtask

  // Reset while ARMED abandons the exchange.
  task automatic test_reset_mid_swap();
    vblank = 1'b0;
    apply_reset();
    swap_req = 1'b1;                  // RUN -> PEND
    @(negedge aclk); swap_req = 1'b0; // PEND -> ARMED (vblank low)
    @(negedge aclk); vblank = 1'b1;   // ARMED -> SWAP
    @(negedge aclk);                  // SWAP -> RUN
    @(negedge aclk);
    #1;
    total++; if (select !== 1'b1) $display("FAIL mid_pre_select got=%0b exp=1", select); else passed++;
    swap_req = 1'b1;                  // RUN -> PEND
    @(negedge aclk); swap_req = 1'b0; vblank = 1'b0;  // PEND -> ARMED
    @(negedge aclk);                  // now ARMED
    aresetn = 1'b0;
    #1;
    total++; if (select !== 1'b0) $display("FAIL mid_select got=%0b exp=0", select); else passed++;
    total++; if (swap_count !== 8'd0) $display("FAIL mid_count got=%0d exp=0", swap_count); else passed++;
    total++; if (swap_done !== 1'b0) $display("FAIL mid_done got=%0b exp=0", swap_done); else passed++;
    vblank = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    r0_valid = 1'b1; r0_x = 12'd2; r0_y = 12'd3; r0_data = 12'h123;
    #1;
    total++; if (r0_ready !== 1'b1) $display("FAIL mid_run_ready got=%0b exp=1", r0_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #1;
      total++; if (swap_done !== 1'b0) $display("FAIL mid_no_done[%0d] got=%0b exp=0", i, swap_done); else passed++;
      total++; if (select !== 1'b0) $display("FAIL mid_no_toggle[%0d] got=%0b exp=0", i, select); else passed++;
    end
    r0_valid = 1'b0;
  endtask

  initial begin
    aresetn  = 1'b0;
    vblank   = 1'b0;
    swap_req = 1'b0;
    r0_valid = 1'b0; r0_x = '0; r0_y = '0; r0_data = '0;
    r1_valid = 1'b0; r1_x = '0; r1_y = '0; r1_data = '0;
    test_reset();
    test_tie();
    test_latency();
    test_clip();
    test_swap();
    test_held();
    test_reset_mid_swap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
